rx_frame_shifter: RTL and testbench
===================================

// Module: rx_frame_shifter
// PURPOSE
//  Parametrised successor to the fixed 10-bit receive shift register in the Rx engine.
//  Shifts serial data in on a per-clock shift strobe and counts bits against a programmable frame length.
//  Presents the completed frame right-justified, with a one-cycle done pulse and start/stop/parity checks.
//  Sits between the Rx bit-timing/sampling logic (drives sh, sdi) and the Rx FIFO/control FSM.
// PARAMETERS
//  WIDTH      10  max frame length in bits (start + data + optional parity + stop); legal >= 3
//  LSB_FIRST  1   1: new bit enters shiftout[WIDTH-1], shifts toward bit 0 (UART order); 0: enters bit 0
//  CNT_W      $clog2(WIDTH+1)  localparam; width of bit_cnt and frame_len
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high; overrides every other input
//  clr        in   1       start new frame: latch frame_len, clear count, preset register
//  sh         in   1       shift enable, level-sampled on each rising clk edge
//  sdi        in   1       serial data in
//  frame_len  in   CNT_W   bits in frame incl. start/stop; sampled only when clr=1
//  parity_en  in   1       frame carries a parity bit just before stop; sampled with clr
//  parity_odd in   1       1: odd parity, 0: even; sampled with clr
//  shiftout   out  WIDTH   raw shift register contents (gen-1 compatible)
//  bit_cnt    out  CNT_W   bits shifted in the current frame
//  busy       out  1       frame in progress
//  frame_done out  1       one-cycle pulse on frame completion
//  data_out   out  WIDTH   completed frame, bit0 = start bit, upper unused bits 0; held until next completion
//  start_err  out  1       start bit was 1; valid with frame_done, held until clr/reset
//  stop_err   out  1       stop (last) bit was 0; same validity
//  par_err    out  1       parity mismatch (0 if parity_en=0); same validity
// BEHAVIOUR
//  Reset: shiftout all 1s (idle line); bit_cnt=0; busy=0; frame_done=0; data_out=0; all errs=0; len_q=WIDTH.
//  Priority per edge: reset > clr > sh.
//  clr: len_q <= clamp(frame_len, 2+parity_en, WIDTH); bit_cnt=0; shiftout all 1s; busy=1; errs cleared.
//   sh in the same cycle as clr is dropped; frame_done forced 0 that cycle.
//  sh=1: shiftout shifts by one regardless of busy. LSB_FIRST=1: {sdi, shiftout[WIDTH-1:1]}.
//   LSB_FIRST=0: {shiftout[WIDTH-2:0], sdi}.
//  busy=0: no counting, no frame_done (legacy monitor mode).
//  sh=1 with busy=1: bit_cnt++.
//   When bit_cnt==len_q-1 (last bit), on the same edge:
//    busy<=0; bit_cnt<=len_q (holds); frame_done<=1; data_out and errs<=checks on post-shift value.
//  Alignment: LSB_FIRST=1 frame = next_shiftout >> (WIDTH-len_q); else bit-reverse of low len_q bits.
//   Either way, first received bit lands at data_out[0].
//  Checks, on the aligned frame:
//   start_err = f[0]
//   stop_err = ~f[len_q-1]
//   par_err = parity_en & (^f[len_q-2:1] != parity_odd); XOR covers data + parity bits
//  frame_done deasserts the next cycle; data_out/errs hold until next completion, clr or reset.
//  Back-to-back sh every cycle supported; latency last sh edge -> frame_done = 1 cycle (registered).
//  Reset mid-frame: abandon frame, reset values, no frame_done.
//  clr mid-frame: restart, no frame_done for the abandoned frame.
// STRUCTURE
//  rx_engine_pkg: CNT_W function, default WIDTH=10, UART idle level constant, frame field offsets.
//  Sub-module rx_frame_check: combinational align + start/stop/parity check (width/len_q/parity in,
//   data + 3 err flags out).
//  Top block: shift register, counter, busy/done logic, output registers.
// TESTING (clk 10 ns; sh held 1 for one clk per bit unless noted)
//  1 reset held 10 clks with sh toggling -> shiftout=10'h3FF, bit_cnt=0, busy=0, frame_done=0, data_out=0.
//  2 clr, frame_len=10, parity_en=0; shift 0, 0xA5 LSB-first, 1:
//     frame_done one cycle after 10th sh; data_out=10'h34A; errs=0; busy=0.
//  3 clr, len=10, parity_en=1, parity_odd=0; data 7'h41 + parity 0 -> par_err=0;
//     repeat with parity 1 -> par_err=1.
//  4 8N1 frame with stop bit 0 -> frame_done pulses, stop_err=1;
//     start bit 1 -> start_err=1; next clr clears both.
//  5 after 4 bits, clr+sh same edge, frame_len=1 -> bit_cnt=0, shiftout=3FF, len_q=2;
//     two sh -> frame_done.
//  6 reset after 5 bits -> reset values, no frame_done;
//     gen-1 cadence (sh toggling every 10 ns, sdi=1, reset released at 100 ns) -> shiftout stays 3FF.

Source files
------------

// File: rtl/rx_frame_shifter_pkg.sv
// Shared constants and helpers for the Rx engine frame shifter.
package rx_frame_shifter_pkg;

   localparam int   DEF_WIDTH = 10;
   localparam logic IDLE_LVL  = 1'b1;
   localparam int   START_POS = 0;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/rx_frame_shifter_if.sv
// Control/status bundle between the Rx sampler, the frame shifter and the Rx FIFO/control FSM.
interface rx_frame_shifter_if
   import rx_frame_shifter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   localparam int CNT_W = cnt_w(WIDTH);

   logic             clr;
   logic             sh;
   logic             sdi;
   logic [CNT_W-1:0] frame_len;
   logic             parity_en;
   logic             parity_odd;
   logic [WIDTH-1:0] shiftout;
   logic [CNT_W-1:0] bit_cnt;
   logic             busy;
   logic             frame_done;
   logic [WIDTH-1:0] data_out;
   logic             start_err;
   logic             stop_err;
   logic             par_err;

   modport master (
      output clr, sh, sdi, frame_len, parity_en, parity_odd,
      input  shiftout, bit_cnt, busy, frame_done, data_out, start_err, stop_err, par_err
   );

   modport slave (
      input  clr, sh, sdi, frame_len, parity_en, parity_odd,
      output shiftout, bit_cnt, busy, frame_done, data_out, start_err, stop_err, par_err
   );

endinterface

// File: rtl/rx_frame_shifter_check.sv
// Combinational frame alignment (first bit at bit 0) and start/stop/parity checks.
module rx_frame_check
   import rx_frame_shifter_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_W     = cnt_w(WIDTH),
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic [WIDTH-1:0] raw,
   input  logic [CNT_W-1:0] len,
   input  logic             parity_en,
   input  logic             parity_odd,
   output logic [WIDTH-1:0] frame,
   output logic             start_err,
   output logic             stop_err,
   output logic             par_err
);

   logic [WIDTH-1:0] frame_c;
   logic [WIDTH-1:0] tmp;
   logic             stop_x;
   logic             par_x;
   int               lenv;

   always_comb begin
      lenv    = int'(len);
      frame_c = '0;
      tmp     = '0;
      stop_x  = 1'b0;
      par_x   = 1'b0;
      if (LSB_FIRST) begin
         frame_c = raw >> (WIDTH - lenv);
      end else begin
         // newest bit sits at bit 0, so the oldest len bits are reversed into place
         tmp = raw << (WIDTH - lenv);
         for (int i = 0; i < WIDTH; i++) begin
            if (i < lenv) frame_c[i] = tmp[WIDTH-1-i];
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         if (i == lenv - 1)             stop_x = ~frame_c[i];
         if (i >= 1 && i <= lenv - 2)   par_x  = par_x ^ frame_c[i];
      end
   end

   assign frame     = frame_c;
   assign start_err = frame_c[START_POS];
   assign stop_err  = stop_x;
   assign par_err   = parity_en & (par_x != parity_odd);

endmodule

// File: rtl/rx_frame_shifter.sv
// Receive shift register with programmable frame length, done pulse and frame checks.
module rx_frame_shifter
   import rx_frame_shifter_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic               clk,
   input logic               reset,
   rx_frame_shifter_if.slave bus
);

   localparam int CNT_W = cnt_w(WIDTH);

   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, len_q, len_clamped, len_lo;
   logic             busy_q, done_q, pe_q, po_q;
   logic [WIDTH-1:0] data_q, frame;
   logic             se_q, te_q, pa_q;
   logic             se_c, te_c, pa_c;
   logic             last_bit;

   always_comb begin
      if (LSB_FIRST) shift_d = {bus.sdi, shift_q[WIDTH-1:1]};
      else           shift_d = {shift_q[WIDTH-2:0], bus.sdi};
   end

   always_comb begin
      len_lo = bus.parity_en ? CNT_W'(3) : CNT_W'(2);
      if (bus.frame_len < len_lo)              len_clamped = len_lo;
      else if (bus.frame_len > CNT_W'(WIDTH))  len_clamped = CNT_W'(WIDTH);
      else                                     len_clamped = bus.frame_len;
   end

   assign last_bit = bus.sh && busy_q && (cnt_q == len_q - 1'b1);

   rx_frame_check #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_check (
      .raw        (shift_d),
      .len        (len_q),
      .parity_en  (pe_q),
      .parity_odd (po_q),
      .frame      (frame),
      .start_err  (se_c),
      .stop_err   (te_c),
      .par_err    (pa_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= {WIDTH{IDLE_LVL}};
         cnt_q   <= '0;
         len_q   <= CNT_W'(WIDTH);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pe_q    <= 1'b0;
         po_q    <= 1'b0;
         data_q  <= '0;
         se_q    <= 1'b0;
         te_q    <= 1'b0;
         pa_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.clr) begin
            len_q   <= len_clamped;
            pe_q    <= bus.parity_en;
            po_q    <= bus.parity_odd;
            cnt_q   <= '0;
            shift_q <= {WIDTH{IDLE_LVL}};
            busy_q  <= 1'b1;
            se_q    <= 1'b0;
            te_q    <= 1'b0;
            pa_q    <= 1'b0;
         end else if (bus.sh) begin
            shift_q <= shift_d;
            // with busy low the register still shifts as a plain line monitor
            if (last_bit) begin
               busy_q <= 1'b0;
               cnt_q  <= len_q;
               done_q <= 1'b1;
               data_q <= frame;
               se_q   <= se_c;
               te_q   <= te_c;
               pa_q   <= pa_c;
            end else if (busy_q) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign bus.shiftout   = shift_q;
   assign bus.bit_cnt    = cnt_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.data_out   = data_q;
   assign bus.start_err  = se_q;
   assign bus.stop_err   = te_q;
   assign bus.par_err    = pa_q;

endmodule

// File: tb/tb_rx_frame_shifter.sv
// Scoreboard bench for rx_frame_shifter: directed frames plus randomized frames vs a bit-list model.
module tb_rx_frame_shifter;

   localparam int WIDTH = 10;
   localparam int CNT_W = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      bit               se, te, pa;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rx_frame_shifter_if #(.WIDTH(WIDTH)) bus();

   rx_frame_shifter #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int               n_tests = 0;
   int               n_fail  = 0;
   int               cyc_n   = 0;
   bit               chk_en  = 0;
   bit               fin     = 0;

   int               m_len  = WIDTH;
   bit               m_pe, m_po, m_busy;
   int               m_cnt;
   bit               hist[$];
   bit               fbits[$];
   logic [WIDTH-1:0] m_data = '0;
   bit               m_se, m_te, m_pa;
   exp_t             sb[$];

   function automatic int clamp_len(input int fl, input bit pe);
      int lo;
      lo = pe ? 3 : 2;
      if (fl < lo)    return lo;
      if (fl > WIDTH) return WIDTH;
      return fl;
   endfunction

   // shiftout as seen on the line: most recent bit at the top, idle 1s behind the history
   function automatic logic [WIDTH-1:0] exp_shift();
      logic [WIDTH-1:0] r;
      for (int k = 0; k < WIDTH; k++)
         r[WIDTH-1-k] = (k < hist.size()) ? hist[hist.size()-1-k] : 1'b1;
      return r;
   endfunction

   task automatic complete_frame();
      exp_t e;
      bit   x;
      e.data = '0;
      for (int i = 0; i < m_len; i++) e.data[i] = fbits[i];
      x = 1'b0;
      for (int i = 1; i <= m_len - 2; i++) x ^= fbits[i];
      e.se  = fbits[0];
      e.te  = !fbits[m_len-1];
      e.pa  = m_pe && (x != m_po);
      e.cyc = cyc_n;
      sb.push_back(e);
      m_data = e.data; m_se = e.se; m_te = e.te; m_pa = e.pa;
   endtask

   task automatic cyc(input bit r, input bit c, input bit s, input bit d);
      reset = r; bus.clr = c; bus.sh = s; bus.sdi = d;
      @(posedge clk);
      cyc_n++;
      if (r) begin
         hist.delete(); fbits.delete();
         m_busy = 0; m_cnt = 0; m_len = WIDTH; m_pe = 0; m_po = 0;
         m_data = '0; m_se = 0; m_te = 0; m_pa = 0;
      end else if (c) begin
         hist.delete(); fbits.delete();
         m_len = clamp_len(int'(bus.frame_len), bus.parity_en);
         m_pe = bus.parity_en; m_po = bus.parity_odd;
         m_busy = 1; m_cnt = 0; m_se = 0; m_te = 0; m_pa = 0;
      end else if (s) begin
         hist.push_back(d);
         if (hist.size() > WIDTH) void'(hist.pop_front());
         if (m_busy) begin
            fbits.push_back(d);
            m_cnt++;
            if (m_cnt == m_len) begin
               m_busy = 0;
               complete_frame();
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input int len, input bit pe, input bit po,
                             input logic [15:0] bits, input int nbits, input bit gaps);
      logic [15:0] b;
      b = bits;
      bus.frame_len = CNT_W'(len); bus.parity_en = pe; bus.parity_odd = po;
      cyc(0, 1, 0, 0);
      for (int i = 0; i < nbits; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 1'($urandom));
         cyc(0, 0, 1, b[i]);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if ({bus.shiftout, bus.bit_cnt, bus.busy, bus.start_err, bus.stop_err, bus.par_err, bus.data_out}
             !== {exp_shift(), CNT_W'(m_cnt), m_busy, m_se, m_te, m_pa, m_data}) begin
            n_fail++;
            $display("FAIL state cyc=%0d got sh=%h cnt=%0d busy=%b err=%b%b%b data=%h exp sh=%h cnt=%0d busy=%b err=%b%b%b data=%h",
                     cyc_n, bus.shiftout, bus.bit_cnt, bus.busy, bus.start_err, bus.stop_err, bus.par_err,
                     bus.data_out, exp_shift(), m_cnt, m_busy, m_se, m_te, m_pa, m_data);
         end
         if (bus.frame_done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL frame_done cyc=%0d got unexpected pulse, exp none", cyc_n);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.cyc != cyc_n || bus.data_out !== e.data ||
                   {bus.start_err, bus.stop_err, bus.par_err} !== {e.se, e.te, e.pa}) begin
                  n_fail++;
                  $display("FAIL frame cyc=%0d got data=%h err=%b%b%b exp cyc=%0d data=%h err=%b%b%b",
                           cyc_n, bus.data_out, bus.start_err, bus.stop_err, bus.par_err,
                           e.cyc, e.data, e.se, e.te, e.pa);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
            n_tests++; n_fail++;
            $display("FAIL frame_done cyc=%0d got no pulse, exp pulse for cyc=%0d", cyc_n, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (fin) begin
            n_tests++;
            if (sb.size() != 0) begin
               n_fail++;
               $display("FAIL drain got %0d pending frames, exp 0", sb.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

   initial begin
      int          l;
      bit          pe, po;
      logic [15:0] bits;
      int          nb;

      reset = 1'b1; bus.clr = 0; bus.sh = 0; bus.sdi = 0;
      bus.frame_len = '0; bus.parity_en = 0; bus.parity_odd = 0;

      // reset held with sh toggling
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, i[0], 1'($urandom));
         chk_en = 1;
      end

      send_frame(10, 0, 0, 16'h034A, 10, 0);                       // 0, A5, 1
      cyc(0, 0, 0, 0);
      send_frame(10, 1, 0, 16'h0200 | (16'h41 << 1), 10, 0);         // even parity ok
      send_frame(10, 1, 0, 16'h0300 | (16'h41 << 1), 10, 1);         // parity error
      send_frame(10, 0, 0, 16'h014A, 10, 0);                        // stop bit 0
      send_frame(10, 0, 0, 16'h034B, 10, 0);                        // start bit 1
      cyc(0, 0, 0, 0);
      send_frame(10, 0, 0, 16'h0000, 0, 0);                         // clr clears errs

      // clr with sh on the same edge, clamped length of 2
      send_frame(10, 0, 0, 16'h00F5, 4, 0);
      bus.frame_len = CNT_W'(1); bus.parity_en = 0;
      cyc(0, 1, 1, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 0, 0);

      // reset mid-frame, then legacy cadence
      send_frame(10, 0, 0, 16'h0015, 5, 0);
      cyc(1, 0, 1, 0);
      repeat (9) cyc(1, 0, 1, 1);
      for (int i = 0; i < 20; i++) cyc(0, 0, i[0], 1);

      for (int f = 0; f < 80; f++) begin
         l    = $urandom_range(0, 15);
         pe   = 1'($urandom);
         po   = 1'($urandom);
         bits = 16'($urandom);
         nb   = clamp_len(l, pe);
         case ($urandom_range(0, 5))
            0:       nb = $urandom_range(0, nb - 1);
            1:       nb = nb + $urandom_range(1, 3);
            default: ;
         endcase
         send_frame(l, pe, po, bits, nb, 1'($urandom));
         if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 1);
      end

      repeat (3) cyc(0, 0, 0, 1);
      fin = 1;
      repeat (5) cyc(0, 0, 0, 1);
      $display("FAIL bench_end got no summary, exp summary");
      $fatal(1, "bench did not terminate");
   end

endmodule
